// File: rtl/fifo_rd_framer.sv
// Read-domain FIFO consumer: pops words, absorbs the one-cycle read latency,
// and emits FRAME_LEN data beats followed by an additive checksum beat.
module fifo_rd_framer #(
    parameter int DATA_W    = 32,
    parameter int FRAME_LEN = 8
) (
    input  logic              rclk,
    input  logic              rst_n,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_rd_data,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    output logic              m_last,
    input  logic              m_ready,
    output logic [15:0]       frame_cnt,
    output logic              busy
);

    localparam int CNT_W = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] FRAME_LEN_C = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST_IDX_C  = CNT_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_CSUM = 2'd2
    } state_t;

    function automatic logic [DATA_W-1:0] csum_add(
        input logic [DATA_W-1:0] acc,
        input logic [DATA_W-1:0] word
    );
        return acc + word;
    endfunction

    state_t              state_r;
    state_t              state_n_s;
    logic [CNT_W-1:0]    issued_r;
    logic [CNT_W-1:0]    captured_r;
    logic                inflight_r;
    logic [DATA_W-1:0]   sum_r;
    logic [DATA_W-1:0]   head_data_r;
    logic                head_last_r;
    logic [DATA_W-1:0]   tail_data_r;
    logic                tail_last_r;
    logic [1:0]          occ_r;
    logic [15:0]         frame_cnt_r;
    logic                busy_r;

    logic                pop_s;
    logic                room_s;
    logic                issue_s;
    logic                capture_s;
    logic                csum_push_s;
    logic                push_s;
    logic [DATA_W-1:0]   push_data_s;
    logic                push_last_s;
    logic [DATA_W-1:0]   head_data_n_s;
    logic                head_last_n_s;
    logic [DATA_W-1:0]   tail_data_n_s;
    logic                tail_last_n_s;
    logic [1:0]          occ_mid_s;
    logic [1:0]          occ_n_s;

    // Handshake, credit and push-source decode
    always_comb begin
        pop_s       = (occ_r != 2'd0) & m_ready;
        capture_s   = inflight_r;
        // Outstanding reads plus buffered beats, net of this cycle's pop, stay below 2
        room_s      = (({1'b0, occ_r} + {2'b00, inflight_r}) < (3'd2 + {2'b00, pop_s}));
        issue_s     = rst_n & ~fifo_empty & room_s & (state_r != ST_CSUM) &
                      (issued_r < FRAME_LEN_C);
        csum_push_s = (state_r == ST_CSUM) & ({1'b0, occ_r} < (3'd2 + {2'b00, pop_s}));
        push_s      = capture_s | csum_push_s;
        if (capture_s) begin
            push_data_s = fifo_rd_data;
            push_last_s = 1'b0;
        end else begin
            push_data_s = sum_r;
            push_last_s = 1'b1;
        end
    end

    assign fifo_rd_en = issue_s;

    // Two-entry output buffer: pop shifts tail to head, push fills first free slot
    always_comb begin
        head_data_n_s = head_data_r;
        head_last_n_s = head_last_r;
        tail_data_n_s = tail_data_r;
        tail_last_n_s = tail_last_r;
        occ_mid_s     = occ_r;
        occ_n_s       = occ_r;
        if (pop_s) begin
            occ_mid_s = occ_r - 2'd1;
            if (occ_r == 2'd2) begin
                head_data_n_s = tail_data_r;
                head_last_n_s = tail_last_r;
            end else begin
                head_last_n_s = 1'b0;
            end
        end else begin
            occ_mid_s = occ_r;
        end
        if (push_s) begin
            occ_n_s = occ_mid_s + 2'd1;
            if (occ_mid_s == 2'd0) begin
                head_data_n_s = push_data_s;
                head_last_n_s = push_last_s;
            end else begin
                tail_data_n_s = push_data_s;
                tail_last_n_s = push_last_s;
            end
        end else begin
            occ_n_s = occ_mid_s;
        end
    end

    // Frame sequencing
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (issue_s) begin
                    state_n_s = ST_DATA;
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_DATA: begin
                // Leave on the edge that captures the final word so the checksum
                // can be queued back-to-back with the last data beat
                if (capture_s && (captured_r == LAST_IDX_C) && !issue_s) begin
                    state_n_s = ST_CSUM;
                end else begin
                    state_n_s = ST_DATA;
                end
            end
            ST_CSUM: begin
                if (csum_push_s) begin
                    state_n_s = ST_IDLE;
                end else begin
                    state_n_s = ST_CSUM;
                end
            end
            default: begin
                state_n_s = ST_IDLE;
            end
        endcase
    end

    // State, counters, checksum and buffer registers
    always_ff @(posedge rclk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            issued_r    <= '0;
            captured_r  <= '0;
            inflight_r  <= 1'b0;
            sum_r       <= '0;
            head_data_r <= '0;
            head_last_r <= 1'b0;
            tail_data_r <= '0;
            tail_last_r <= 1'b0;
            occ_r       <= 2'd0;
            frame_cnt_r <= 16'd0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_n_s;
            inflight_r  <= issue_s;
            head_data_r <= head_data_n_s;
            head_last_r <= head_last_n_s;
            tail_data_r <= tail_data_n_s;
            tail_last_r <= tail_last_n_s;
            occ_r       <= occ_n_s;
            busy_r      <= (state_n_s != ST_IDLE) | (occ_n_s != 2'd0);
            if (csum_push_s) begin
                sum_r      <= '0;
                captured_r <= '0;
                issued_r   <= '0;
            end else begin
                if (capture_s) begin
                    sum_r      <= csum_add(sum_r, fifo_rd_data);
                    captured_r <= captured_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    sum_r      <= sum_r;
                    captured_r <= captured_r;
                end
                if (issue_s) begin
                    issued_r <= issued_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    issued_r <= issued_r;
                end
            end
            if (pop_s && head_last_r) begin
                frame_cnt_r <= frame_cnt_r + 16'd1;
            end else begin
                frame_cnt_r <= frame_cnt_r;
            end
        end
    end

    assign m_valid   = (occ_r != 2'd0);
    assign m_data    = head_data_r;
    assign m_last    = head_last_r;
    assign frame_cnt = frame_cnt_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_fifo_rd_framer.sv
// Directed scoreboard bench for fifo_rd_framer: FRAME_LEN=4 main instance plus
// a FRAME_LEN=2 instance for checksum wrap-around.
module tb_fifo_rd_framer;

    logic        rclk = 1'b0;
    logic        rst_n;
    logic        m_ready;
    logic        starve;

    logic        fifo_empty, fifo_rd_en, m_valid, m_last, busy;
    logic [31:0] fifo_rd_data = 32'd0;
    logic [31:0] m_data;
    logic [15:0] frame_cnt;

    logic        b_empty, b_rd_en, b_valid, b_last, b_busy;
    logic [31:0] b_rd_data = 32'd0;
    logic [31:0] b_data;
    logic [15:0] b_frame_cnt;

    logic [31:0] mem [0:255];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic [31:0] b_mem [0:3];
    int          b_wr = 0;
    int          b_rd_ptr = 0;

    logic [32:0] exp_q[$];
    logic [32:0] b_exp_q[$];
    logic [31:0] m_sum = 32'd0;
    int          m_n = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    int          issue_cnt = 0;
    logic        hold_v = 1'b0;
    logic [33:0] hold_val = 34'd0;

    always #5 rclk = ~rclk;

    assign fifo_empty = starve | (rd_ptr == wr_ptr);
    assign b_empty    = (b_rd_ptr == b_wr);

    // FIFO read-port models: data appears the cycle after an accepted pop
    always @(posedge rclk) begin
        if (fifo_rd_en) begin
            fifo_rd_data <= mem[rd_ptr];
            rd_ptr       <= rd_ptr + 1;
        end
        if (b_rd_en) begin
            b_rd_data <= b_mem[b_rd_ptr];
            b_rd_ptr  <= b_rd_ptr + 1;
        end
    end

    fifo_rd_framer #(.DATA_W(32), .FRAME_LEN(4)) dut (
        .rclk(rclk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .fifo_rd_data(fifo_rd_data), .m_data(m_data), .m_valid(m_valid), .m_last(m_last),
        .m_ready(m_ready), .frame_cnt(frame_cnt), .busy(busy)
    );

    fifo_rd_framer #(.DATA_W(32), .FRAME_LEN(2)) dut_b (
        .rclk(rclk), .rst_n(rst_n), .fifo_empty(b_empty), .fifo_rd_en(b_rd_en),
        .fifo_rd_data(b_rd_data), .m_data(b_data), .m_valid(b_valid), .m_last(b_last),
        .m_ready(1'b1), .frame_cnt(b_frame_cnt), .busy(b_busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Load a word into the source FIFO and queue its expected beats
    task automatic push_word(input logic [31:0] w);
        mem[wr_ptr] = w;
        wr_ptr = wr_ptr + 1;
        exp_q.push_back({1'b0, w});
        m_sum = m_sum + w;
        m_n++;
        if (m_n == 4) begin
            exp_q.push_back({1'b1, m_sum});
            m_sum = 32'd0;
            m_n = 0;
        end
    endtask

    // One clock: check at the falling edge, return just after the next rising edge
    task automatic tick();
        @(negedge rclk);
        if (rst_n) begin
            if (fifo_empty) chk("rd_en_while_empty", {63'd0, fifo_rd_en}, 64'd0);
            if (b_empty) chk("b_rd_en_while_empty", {63'd0, b_rd_en}, 64'd0);
            if (hold_v) chk("hold_stable", {30'd0, m_valid, m_last, m_data}, {30'd0, hold_val});
            if (fifo_rd_en) issue_cnt++;
            if (m_valid && m_ready) begin
                chk("beat_expected", {63'd0, exp_q.size() != 0}, 64'd1);
                if (exp_q.size() != 0) begin
                    chk("beat", {31'd0, m_last, m_data}, {31'd0, exp_q[0]});
                    exp_q.delete(0);
                end
            end
            if (b_valid) begin
                chk("b_beat_expected", {63'd0, b_exp_q.size() != 0}, 64'd1);
                if (b_exp_q.size() != 0) begin
                    chk("b_beat", {31'd0, b_last, b_data}, {31'd0, b_exp_q[0]});
                    b_exp_q.delete(0);
                end
            end
            hold_v   = m_valid & ~m_ready;
            hold_val = {m_valid, m_last, m_data};
        end else begin
            hold_v = 1'b0;
        end
        @(posedge rclk);
        #1;
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int lat;
        int n;
        int bubbles;
        logic started;
        rst_n   = 1'b0;
        m_ready = 1'b1;
        starve  = 1'b0;

        // Reset state, with source data already waiting
        push_word(32'd1); push_word(32'd2); push_word(32'd3); push_word(32'd4);
        b_mem[0] = 32'hFFFF_FFFF; b_mem[1] = 32'h0000_0003; b_wr = 2;
        b_exp_q.push_back({1'b0, 32'hFFFF_FFFF});
        b_exp_q.push_back({1'b0, 32'h0000_0003});
        b_exp_q.push_back({1'b1, 32'h0000_0002});
        repeat (3) tick();
        chk("rst_rd_en", {63'd0, fifo_rd_en}, 64'd0);
        chk("rst_outputs", {45'd0, m_valid, m_last, busy, frame_cnt}, 64'd0);
        chk("rst_m_data", {32'd0, m_data}, 64'd0);

        // Single frame 1,2,3,4 and read latency
        rst_n = 1'b1;
        #1;
        n = 0;
        while (!fifo_rd_en && n < 20) begin tick(); n++; end
        chk("first_issue_seen", {63'd0, fifo_rd_en}, 64'd1);
        lat = 0;
        do begin tick(); lat++; end while (!m_valid && lat < 10);
        chk("first_valid_latency", 64'(lat), 64'd2);
        drain("single_frame_drain", 50);
        chk("single_frame_cnt", {48'd0, frame_cnt}, 64'd1);
        n = 0;
        while (b_exp_q.size() != 0 && n < 30) begin tick(); n++; end
        chk("wrap_drain", 64'(b_exp_q.size()), 64'd0);
        chk("wrap_frame_cnt", {48'd0, b_frame_cnt}, 64'd1);

        // Backpressure mid-frame for 6 cycles
        for (int i = 0; i < 8; i++) push_word(32'h100 + 32'(i));
        repeat (3) tick();
        m_ready   = 1'b0;
        issue_cnt = 0;
        repeat (6) tick();
        chk("bp_issue_limit", {63'd0, issue_cnt <= 2}, 64'd1);
        chk("bp_rd_en_stopped", {63'd0, fifo_rd_en}, 64'd0);
        chk("bp_valid_held", {63'd0, m_valid}, 64'd1);
        m_ready = 1'b1;
        drain("bp_drain", 100);
        chk("bp_frame_cnt", {48'd0, frame_cnt}, 64'd3);

        // Starved source across 3 frames
        for (int i = 0; i < 12; i++) push_word($urandom);
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            repeat (3) tick();
            starve = ~starve;
            n += 3;
        end
        starve = 1'b0;
        drain("starve_drain", 50);
        chk("starve_frame_cnt", {48'd0, frame_cnt}, 64'd6);

        // Reset after 2 of 4 words
        m_ready = 1'b0;
        push_word(32'd11); push_word(32'd12);
        repeat (5) tick();
        chk("pre_rst_buffered", {62'd0, m_valid, busy}, 64'd3);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        m_sum = 32'd0;
        m_n = 0;
        chk("midrst_outputs", {45'd0, m_valid, m_last, busy, frame_cnt}, 64'd0);
        chk("midrst_m_data", {32'd0, m_data}, 64'd0);
        m_ready = 1'b1;
        push_word(32'd5); push_word(32'd6); push_word(32'd7); push_word(32'd8);
        chk("midrst_exp_csum", {31'd0, exp_q[4]}, {31'd0, 1'b1, 32'h0000_001A});
        drain("midrst_drain", 50);
        chk("midrst_frame_cnt", {48'd0, frame_cnt}, 64'd1);

        // Ten back-to-back frames
        for (int i = 0; i < 40; i++) push_word(32'h1000 * 32'(i + 1) + 32'(i));
        bubbles = 0;
        started = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
            if (started && !m_valid && exp_q.size() != 0) bubbles++;
            if (m_valid) started = 1'b1;
        end
        chk("b2b_drain", 64'(exp_q.size()), 64'd0);
        chk("b2b_bubbles", {63'd0, bubbles <= 10}, 64'd1);
        chk("b2b_frame_cnt", {48'd0, frame_cnt}, 64'd11);
        chk("b2b_idle", {62'd0, busy, m_valid}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
